// File: rtl/prbs_checker_pkg.sv
// rx_package: shared types and constants for the receive-side PRBS checker.
//   PRBS_CHK_STATE      - checker FSM state encoding
//   PRBS_CHK_CNT_FORMAT - default-width unsigned counter type
//   PRBS_DEF_*          - default PRBS7 polynomial (x^7 + x^6 + 1), kept in
//                         step with the TX prbs generator
package rx_package;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } PRBS_CHK_STATE;

  localparam int PRBS_CHK_CNT_W = 40;
  typedef logic [PRBS_CHK_CNT_W-1:0] PRBS_CHK_CNT_FORMAT;

  localparam int PRBS_DEF_N     = 7;
  localparam int PRBS_DEF_TAP_A = 7;
  localparam int PRBS_DEF_TAP_B = 6;

endpackage

// File: rtl/prbs_checker_predictor.sv
// prbs_predictor: PRBS shift register s[1..PRBS_N] plus feedback XOR.
// s[1] holds the most recent bit. pred_bit_o is the bit the polynomial
// expects next; on each shift either the external bit or the prediction
// is shifted in.
// Ports:
//   clk_sys    - system clock
//   rst        - synchronous active-high reset, clears the register
//   shift_en_i - advance the register by one bit
//   sel_ext_i  - 1: shift in ext_bit_i (self-synchronising), 0: free-run
//   ext_bit_i  - external bit
//   pred_bit_o - s[TAP_A] ^ s[TAP_B]
module prbs_predictor
  import rx_package::*;
#(
  parameter int PRBS_N = PRBS_DEF_N,
  parameter int TAP_A  = PRBS_DEF_TAP_A,
  parameter int TAP_B  = PRBS_DEF_TAP_B
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic shift_en_i,
  input  logic sel_ext_i,
  input  logic ext_bit_i,
  output logic pred_bit_o
);

  logic [PRBS_N:1] s_q;
  logic [PRBS_N:1] s_d;
  logic            shift_bit;

  assign pred_bit_o = s_q[TAP_A] ^ s_q[TAP_B];
  assign shift_bit  = sel_ext_i ? ext_bit_i : pred_bit_o;
  assign s_d        = {s_q[PRBS_N-1:1], shift_bit};

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      s_q <= '0;
    end else if (shift_en_i) begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: BER checker for the recovered CDR bit stream.
// Self-synchronises a local PRBS predictor, declares lock after LOCK_LEN
// consecutive matches, then free-runs the predictor and counts checked bits
// and errors. Too many errors within one WIN_LEN-bit window drops lock.
// Ports:
//   clk_sys    - system clock
//   rst        - synchronous active-high reset (priority over everything)
//   cke_rx     - one-cycle strobe per recovered bit
//   data_in    - recovered bit, valid with cke_rx
//   clear      - synchronous clear of bit/err counters and sat
//   inject_err - (only with PRBS_CHECKER_ERR_INJECT_EN) rising edge inverts
//                the next strobed bit
//   locked     - FSM is in LOCKED
//   bit_count  - bits checked while locked (saturating)
//   err_count  - errors seen while locked (saturating)
//   err_pulse  - one-cycle pulse per error seen while locked
//   sat        - sticky: a counter reached all-ones
// Optional feature macro: PRBS_CHECKER_ERR_INJECT_EN
module prbs_checker
  import rx_package::*;
#(
  parameter int PRBS_N      = PRBS_DEF_N,
  parameter int TAP_A       = PRBS_DEF_TAP_A,
  parameter int TAP_B       = PRBS_DEF_TAP_B,
  parameter int LOCK_LEN    = 64,
  parameter int WIN_LEN     = 128,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = PRBS_CHK_CNT_W
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             cke_rx,
  input  logic             data_in,
  input  logic             clear,
`ifdef PRBS_CHECKER_ERR_INJECT_EN
  input  logic             inject_err,
`endif
  output logic             locked,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_pulse,
  output logic             sat
);

  localparam int SEED_W  = $clog2(PRBS_N + 1);
  localparam int MATCH_W = 16;
  localparam int WIN_W   = $clog2(WIN_LEN + 1);

  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(PRBS_N - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_LEN - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
  localparam logic [WIN_W-1:0]   ERRS_LAST  = WIN_W'(UNLOCK_ERRS - 1);

  PRBS_CHK_STATE      state_q;
  logic [SEED_W-1:0]  seed_cnt_q;
  logic [MATCH_W-1:0] match_cnt_q;
  logic [WIN_W-1:0]   win_bits_q;
  logic [WIN_W-1:0]   win_errs_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_d;
  logic               err_pulse_q;
  logic               sat_q;

  logic rx_bit;
  logic pred_bit;
  logic mismatch;

`ifdef PRBS_CHECKER_ERR_INJECT_EN
  logic inj_prev_q;
  logic inj_arm_q;

  // The armed injection is consumed by the next strobe; a new rising edge
  // in the same cycle re-arms for the strobe after.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      inj_prev_q <= 1'b0;
      inj_arm_q  <= 1'b0;
    end else begin
      inj_prev_q <= inject_err;
      inj_arm_q  <= (inj_arm_q & ~cke_rx) | (inject_err & ~inj_prev_q);
    end
  end

  assign rx_bit = data_in ^ inj_arm_q;
`else
  assign rx_bit = data_in;
`endif

  assign mismatch  = rx_bit ^ pred_bit;
  assign bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
  assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);

  // Outside LOCKED the register tracks the incoming data; once locked it
  // free-runs so a single bad bit cannot corrupt later predictions.
  prbs_predictor #(
    .PRBS_N (PRBS_N),
    .TAP_A  (TAP_A),
    .TAP_B  (TAP_B)
  ) u_pred (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .shift_en_i (cke_rx),
    .sel_ext_i  (state_q != LOCKED),
    .ext_bit_i  (rx_bit),
    .pred_bit_o (pred_bit)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= SEED;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;

      if (cke_rx) begin
        case (state_q)
          SEED: begin
            if (seed_cnt_q == SEED_LAST) begin
              state_q     <= SEARCH;
              seed_cnt_q  <= '0;
              match_cnt_q <= '0;
            end else begin
              seed_cnt_q <= seed_cnt_q + SEED_W'(1);
            end
          end
          SEARCH: begin
            if (mismatch) begin
              state_q    <= SEED;
              seed_cnt_q <= '0;
            end else if (match_cnt_q == MATCH_LAST) begin
              state_q    <= LOCKED;
              win_bits_q <= '0;
              win_errs_q <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MATCH_W'(1);
            end
          end
          LOCKED: begin
            err_pulse_q <= mismatch;
            if (mismatch && (win_errs_q == ERRS_LAST)) begin
              state_q    <= SEED;
              seed_cnt_q <= '0;
            end
            // The bit that completes a window belongs to the old window.
            if (win_bits_q == WIN_LAST) begin
              win_bits_q <= '0;
              win_errs_q <= '0;
            end else begin
              win_bits_q <= win_bits_q + WIN_W'(1);
              if (mismatch) begin
                win_errs_q <= win_errs_q + WIN_W'(1);
              end
            end
          end
          default: begin
            state_q    <= SEED;
            seed_cnt_q <= '0;
          end
        endcase
      end

      // clear beats a simultaneous strobe: the bit is simply not counted.
      if (clear) begin
        bit_cnt_q <= '0;
        err_cnt_q <= '0;
        sat_q     <= 1'b0;
      end else if (cke_rx && (state_q == LOCKED)) begin
        bit_cnt_q <= bit_cnt_d;
        if (mismatch) begin
          err_cnt_q <= err_cnt_d;
        end
        sat_q <= sat_q | (&bit_cnt_d) | (mismatch & (&err_cnt_d));
      end
    end
  end

  assign locked    = (state_q == LOCKED);
  assign bit_count = bit_cnt_q;
  assign err_count = err_cnt_q;
  assign err_pulse = err_pulse_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a PRBS7 generator drives both a default
// instance and a CNT_W=4 instance with one strobe every third clock.
module tb_prbs_checker;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        cke_rx  = 1'b0;
  logic        data_in = 1'b0;
  logic        clear   = 1'b0;

  logic        locked,  locked4;
  logic [39:0] bit_count, err_count;
  logic [3:0]  bit_count4, err_count4;
  logic        err_pulse, err_pulse4;
  logic        sat, sat4;

  int unsigned n_checks = 0;
  int unsigned n_passed = 0;
  int          pulse_cnt = 0;
  logic [7:1]  gen_q = 7'b1010011;

  always #5 clk_sys = ~clk_sys;

  prbs_checker dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .cke_rx    (cke_rx),
    .data_in   (data_in),
    .clear     (clear),
    .locked    (locked),
    .bit_count (bit_count),
    .err_count (err_count),
    .err_pulse (err_pulse),
    .sat       (sat)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .cke_rx    (cke_rx),
    .data_in   (data_in),
    .clear     (clear),
    .locked    (locked4),
    .bit_count (bit_count4),
    .err_count (err_count4),
    .err_pulse (err_pulse4),
    .sat       (sat4)
  );

  typedef struct {
    string  name;
    int     n_bits;
    int     err_every;   // 0: clean, else invert bit i when i%err_every==err_every-1
    bit     clr;         // assert clear with the first strobe
    bit     exp_locked;
    longint exp_bits;
    longint exp_errs;
    int     exp_pulses;  // err_pulse cycles during this vector
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_passed++;
  endtask

  // x^7 + x^6 + 1 generator; the checker must predict exactly this stream.
  task automatic gen(output logic b);
    b = gen_q[7] ^ gen_q[6];
    gen_q = {gen_q[6:1], b};
  endtask

  // Called at a negedge; one strobe then two idle cycles. err_pulse is
  // sampled at every negedge so each high cycle is counted once.
  task automatic send(input logic b, input logic clr);
    data_in = b;
    cke_rx  = 1'b1;
    clear   = clr;
    @(negedge clk_sys);
    if (err_pulse) pulse_cnt++;
    cke_rx = 1'b0;
    clear  = 1'b0;
    @(negedge clk_sys);
    if (err_pulse) pulse_cnt++;
    @(negedge clk_sys);
    if (err_pulse) pulse_cnt++;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen(b);
      send(b, 1'b0);
    end
  endtask

  initial begin
    logic b;
    int   p0;
    bit   inv;

    tbl[0]  = '{"pre_lock",     70,   0, 1'b0, 1'b0,    0,  0, 0};
    tbl[1]  = '{"lock",          1,   0, 1'b0, 1'b1,    0,  0, 0};
    tbl[2]  = '{"locked20",     20,   0, 1'b0, 1'b1,   20,  0, 0};
    tbl[3]  = '{"locked1000",  980,   0, 1'b0, 1'b1, 1000,  0, 0};
    tbl[4]  = '{"three_errs",  300, 100, 1'b0, 1'b1, 1300,  3, 3};
    tbl[5]  = '{"align_win",   108,   0, 1'b0, 1'b1, 1408,  3, 0};
    tbl[6]  = '{"eight_errs",   32,   4, 1'b0, 1'b0, 1440, 11, 8};
    tbl[7]  = '{"relock_pre",   70,   0, 1'b0, 1'b0, 1440, 11, 0};
    tbl[8]  = '{"relock",        1,   0, 1'b0, 1'b1, 1440, 11, 0};
    tbl[9]  = '{"burst_unlock",  8,   1, 1'b0, 1'b0, 1448, 19, 8};
    tbl[10] = '{"search_errs", 400,  20, 1'b1, 1'b0,    0,  0, 0};
    tbl[11] = '{"relock2_pre",  70,   0, 1'b0, 1'b0,    0,  0, 0};
    tbl[12] = '{"relock2",       1,   0, 1'b0, 1'b1,    0,  0, 0};
    tbl[13] = '{"count5",        5,   0, 1'b0, 1'b1,    5,  0, 0};
    tbl[14] = '{"clear_err",     1,   1, 1'b1, 1'b1,    0,  0, 1};

    repeat (3) @(negedge clk_sys);
    chk("rst_locked",    longint'(locked),    0);
    chk("rst_bit_count", longint'(bit_count), 0);
    chk("rst_sat",       longint'(sat),       0);
    rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      p0 = pulse_cnt;
      for (int i = 0; i < tbl[v].n_bits; i++) begin
        gen(b);
        inv = (tbl[v].err_every > 0) && ((i % tbl[v].err_every) == tbl[v].err_every - 1);
        send(b ^ inv, tbl[v].clr && (i == 0));
      end
      chk({tbl[v].name, "_locked"}, longint'(locked),    longint'(tbl[v].exp_locked));
      chk({tbl[v].name, "_bits"},   longint'(bit_count), tbl[v].exp_bits);
      chk({tbl[v].name, "_errs"},   longint'(err_count), tbl[v].exp_errs);
      chk({tbl[v].name, "_pulses"}, longint'(pulse_cnt - p0), longint'(tbl[v].exp_pulses));
      if (v == 2) begin
        chk("cnt4_bits_sat", longint'(bit_count4), 15);
        chk("cnt4_sat",      longint'(sat4),       1);
        chk("cnt40_sat",     longint'(sat),        0);
      end
      if (v == 14) chk("clear_err_sat", longint'(sat), 0);
    end

    // Saturate the narrow instance again, then reset during an erroneous strobe.
    send_clean(16);
    chk("cnt4_resat_bits", longint'(bit_count4), 15);
    chk("cnt4_resat",      longint'(sat4),       1);
    chk("cnt40_bits16",    longint'(bit_count),  16);
    gen(b);
    data_in = ~b;
    cke_rx  = 1'b1;
    rst     = 1'b1;
    @(negedge clk_sys);
    chk("midrst_locked",    longint'(locked),     0);
    chk("midrst_bits",      longint'(bit_count),  0);
    chk("midrst_errs",      longint'(err_count),  0);
    chk("midrst_pulse",     longint'(err_pulse),  0);
    chk("midrst_locked4",   longint'(locked4),    0);
    chk("midrst_bits4",     longint'(bit_count4), 0);
    chk("midrst_sat4",      longint'(sat4),       0);
    rst    = 1'b0;
    cke_rx = 1'b0;
    @(negedge clk_sys);

    // Lock latency after reset: locked must appear exactly one cycle after
    // the 71st strobe.
    send_clean(70);
    chk("postrst_prelock", longint'(locked), 0);
    gen(b);
    data_in = b;
    cke_rx  = 1'b1;
    @(negedge clk_sys);
    cke_rx = 1'b0;
    chk("postrst_lock_1cyc", longint'(locked), 1);
    @(negedge clk_sys);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
